regfile_wb_arbiter: RTL and testbench

Write-back arbiter that shares the single write port of the 32×32 register file between two requesters: the ALU write-back stage and the load (memory) write-back stage. Each requester gets a one-entry holding register behind a valid/ready handshake. A per-cycle arbiter grants one held entry and drives registered `write_addr`/`write_data`/`write_enable` into the register file. It also enforces the hardwired-zero register rule (register 31) and counts write-port contention cycles.

---
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and load write-back stages.
// Build with WB_ARB_ROUND_ROBIN_EN defined for round-robin arbitration (default: mem over alu).
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_enable,
  output logic [15:0]           contention_count
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  logic      hold_alu_valid;
  logic      hold_mem_valid;
  wb_entry_t hold_alu;
  wb_entry_t hold_mem;

  logic grant_alu;
  logic grant_mem;
  logic contended;
  logic prefer_alu;
  logic alu_load;
  logic mem_load;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Pointer flips only on contended grants so the loser is served next.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_alu <= 1'b0;
    end else if (contended) begin
      prefer_alu <= grant_mem;
    end
  end
`else
  assign prefer_alu = 1'b0;
`endif

  // Grant depends only on hold state and the pointer, keeping ready free of valid paths.
  always_comb begin
    grant_mem = hold_mem_valid & (~hold_alu_valid | ~prefer_alu);
    grant_alu = hold_alu_valid & ~grant_mem;
    contended = hold_alu_valid & hold_mem_valid;
  end

  assign alu_ready = ~hold_alu_valid | grant_alu;
  assign mem_ready = ~hold_mem_valid | grant_mem;

  // Writes to the hardwired-zero register complete the handshake but are dropped.
  always_comb begin
    alu_load = alu_valid & alu_ready & (alu_addr != ZERO_ADDR);
    mem_load = mem_valid & mem_ready & (mem_addr != ZERO_ADDR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_alu_valid <= 1'b0;
      hold_alu       <= '0;
    end else if (alu_load) begin
      hold_alu_valid <= 1'b1;
      hold_alu       <= '{addr: alu_addr, data: alu_data};
    end else if (grant_alu) begin
      hold_alu_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_mem_valid <= 1'b0;
      hold_mem       <= '0;
    end else if (mem_load) begin
      hold_mem_valid <= 1'b1;
      hold_mem       <= '{addr: mem_addr, data: mem_data};
    end else if (grant_mem) begin
      hold_mem_valid <= 1'b0;
    end
  end

  // Address/data keep their last value when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= grant_alu | grant_mem;
      if (grant_mem) begin
        write_addr <= hold_mem.addr;
        write_data <= hold_mem.data;
      end else if (grant_alu) begin
        write_addr <= hold_alu.addr;
        write_data <= hold_alu.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      contention_count <= '0;
    end else if (contended && (contention_count != CNT_MAX)) begin
      contention_count <= contention_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: reference model of pending writes per requester,
// expected writes queued at grant time and popped by an independent monitor.
module tb_regfile_wb_arbiter;

  localparam logic [4:0] ZR = 5'd31;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr;
  logic [31:0] alu_data, mem_data;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [15:0] contention_count;

  regfile_wb_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_addr         (alu_addr),
    .alu_data         (alu_data),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .write_enable     (write_enable),
    .contention_count (contention_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] dut_rf [32];
  wr_t         mon_e;

  // Reference model: at most one pending write per requester, plus policy state.
  bit          pa_v = 1'b0, pm_v = 1'b0;
  wr_t         pa, pm;
  bit          m_we = 1'b0;
  int          m_cnt = 0;
  bit          m_last_mem = 1'b0;
  bit          stall_a = 1'b0, stall_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // 0 = nobody pending, 1 = alu wins, 2 = mem wins.
  function automatic int pick();
    if (pa_v && pm_v) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      return m_last_mem ? 1 : 2;
`else
      return 2;
`endif
    end
    if (pm_v) return 2;
    if (pa_v) return 1;
    return 0;
  endfunction

  task automatic model_edge();
    int w;
    bit ra, rm;
    if (reset) begin
      pa_v = 0; pm_v = 0; m_we = 0; m_cnt = 0; m_last_mem = 0;
      stall_a = alu_valid; stall_m = mem_valid;
      return;
    end
    w  = pick();
    ra = !pa_v || (w == 1);
    rm = !pm_v || (w == 2);
    if (pa_v && pm_v) begin
      if (m_cnt < 65535) m_cnt++;
      m_last_mem = (w == 2);
    end
    m_we = (w != 0);
    if (w == 1) begin exp_q.push_back(pa); pa_v = 0; end
    if (w == 2) begin exp_q.push_back(pm); pm_v = 0; end
    stall_a = alu_valid && !ra;
    stall_m = mem_valid && !rm;
    if (alu_valid && ra && alu_addr != ZR) begin pa_v = 1; pa = '{alu_addr, alu_data}; end
    if (mem_valid && rm && mem_addr != ZR) begin pm_v = 1; pm = '{mem_addr, mem_data}; end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    alu_valid = 0; mem_valid = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rand_inputs();
    if (!stall_a) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_addr  = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
    end
    if (!stall_m) begin
      mem_valid = 1'($urandom_range(0, 1));
      mem_addr  = 5'($urandom_range(0, 31));
      mem_data  = $urandom;
    end
  endtask

  // Monitor: compares DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("write_enable", 32'(write_enable), 32'(m_we));
    if (write_enable) begin
      dut_rf[write_addr] = write_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL write_order: write addr %0d data %0h, expected no write at %0t",
                 write_addr, write_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(write_addr), 32'(mon_e.addr));
        chk("write_data", write_data, mon_e.data);
      end
    end
    chk("alu_ready", 32'(alu_ready), 32'(!pa_v || pick() == 1));
    chk("mem_ready", 32'(mem_ready), 32'(!pm_v || pick() == 2));
    chk("contention_count", 32'(contention_count), 32'(m_cnt));
  end

  initial begin
    reset = 1; alu_valid = 1; alu_addr = 5'd7; alu_data = 32'd77;
    mem_valid = 1; mem_addr = 5'd9; mem_data = 32'd99;
    cycle();
    cycle();
    chk("reset_we", 32'(write_enable), 32'h0);
    chk("reset_addr", 32'(write_addr), 32'h0);
    chk("reset_data", write_data, 32'h0);
    chk("reset_cnt", 32'(contention_count), 32'h0);
    chk("reset_alu_ready", 32'(alu_ready), 32'h1);
    chk("reset_mem_ready", 32'(mem_ready), 32'h1);

    // First accept on the first edge after reset deasserts.
    reset = 0;
    cycle();
    alu_valid = 0; mem_valid = 0;
    chk("first_accept_we", 32'(write_enable), 32'h0);
    cycle();
    chk("first_write_addr", 32'(write_addr), 32'd9);
    chk("first_write_data", write_data, 32'd99);
    chk("first_contention", 32'(contention_count), 32'd1);
    cycle();
    chk("second_write_addr", 32'(write_addr), 32'd7);
    idle(3);
    reset = 1; cycle(); reset = 0;

    // Lone ALU stream.
    alu_valid = 1;
    alu_addr = 5'd1; alu_data = 32'h11; cycle();
    alu_addr = 5'd2; alu_data = 32'h22; cycle();
    alu_addr = 5'd3; alu_data = 32'h33; cycle();
    idle(4);
    chk("stream_r1", dut_rf[1], 32'h11);
    chk("stream_r2", dut_rf[2], 32'h22);
    chk("stream_r3", dut_rf[3], 32'h33);
    chk("stream_cnt", 32'(contention_count), 32'd0);

    // Simultaneous requests to the same register, twice.
    alu_valid = 1; alu_addr = 5'd4; alu_data = 32'hA;
    mem_valid = 1; mem_addr = 5'd4; mem_data = 32'hB;
    cycle();
    idle(4);
    chk("simul_r4", dut_rf[4], 32'hA);
    chk("simul_cnt", 32'(contention_count), 32'd1);
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hC;
    mem_valid = 1; mem_addr = 5'd5; mem_data = 32'hD;
    cycle();
    idle(4);
`ifdef WB_ARB_ROUND_ROBIN_EN
    chk("simul2_r5", dut_rf[5], 32'hD);
`else
    chk("simul2_r5", dut_rf[5], 32'hC);
`endif
    chk("simul2_cnt", 32'(contention_count), 32'd2);

    // Zero-register drop.
    mem_valid = 1; mem_addr = ZR; mem_data = 32'hDEAD;
    chk("zero_mem_ready", 32'(mem_ready), 32'h1);
    cycle();
    idle(4);
    chk("zero_cnt", 32'(contention_count), 32'd2);

    // Randomized traffic with protocol-respecting stalls.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end
    for (int i = 0; i < 8; i++) begin
      if (!stall_a) alu_valid = 0;
      if (!stall_m) mem_valid = 0;
      cycle();
    end
    idle(3);

    // Saturation with both sides streaming, then reset with both holds valid.
    for (int i = 0; i < 65600; i++) begin
      if (!stall_a) begin
        alu_valid = 1; alu_addr = 5'($urandom_range(1, 30)); alu_data = $urandom;
      end
      if (!stall_m) begin
        mem_valid = 1; mem_addr = 5'($urandom_range(1, 30)); mem_data = $urandom;
      end
      cycle();
    end
    chk("sat_cnt", 32'(contention_count), 32'hFFFF);
    reset = 1;
    cycle();
    reset = 0;
    chk("midreset_we", 32'(write_enable), 32'h0);
    chk("midreset_cnt", 32'(contention_count), 32'h0);
    chk("midreset_alu_ready", 32'(alu_ready), 32'h1);
    chk("midreset_mem_ready", 32'(mem_ready), 32'h1);
    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
